// File: rtl/pause_pkg.sv
// Shared FSM encoding and timing constants for the pause/dim block.
package pause_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_DIMMED = 2'd2
  } state_t;

  localparam int CYCLES_PER_MHZ = 1_000_000;

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: emits a single-cycle tick every TICK_CYCLES enabled cycles.
module sec_tick
  import pause_pkg::*;
#(
  parameter int CLKSPD      = 24,
  parameter int TICK_CYCLES = CLKSPD * CYCLES_PER_MHZ,
  localparam int CW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          wrap;

  assign wrap = (count_q == CW'(TICK_CYCLES - 1));
  assign tick = enable & wrap;

  // Disabled means held at zero, so every pause starts a fresh second.
  always_comb begin
    count_d = count_q;
    if (!enable) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pause_dim.sv
// Core pause controller: merges pause sources into pause_cpu and halves the
// video intensity after DIM_SECONDS of uninterrupted pause.
module pause_dim
  import pause_pkg::*;
#(
  parameter int RW          = 4,
  parameter int GW          = 4,
  parameter int BW          = 4,
  parameter int CLKSPD      = 24,
  parameter int DIM_SECONDS = 10,
  // Override for a shorter second; defaults to one real second of clk_sys.
  parameter int TICK_CYCLES = CLKSPD * CYCLES_PER_MHZ,
  localparam int PW         = RW + GW + BW,
  localparam int SW         = (DIM_SECONDS > 0) ? $clog2(DIM_SECONDS + 1) : 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          user_button,
  input  logic          pause_request,
  input  logic          OSD_STATUS,
  input  logic [1:0]    options,
  input  logic [PW-1:0] rgb_in,
  output logic          pause_cpu,
  output logic [PW-1:0] rgb_out,
  output state_t        dbg_state_o,
  output logic [SW-1:0] dbg_seconds_o
);

  localparam logic [SW-1:0] SEC_MAX = SW'(DIM_SECONDS);

  logic          btn_q;
  logic          user_pause_q, user_pause_d;
  logic          pause_cpu_q, pause_cpu_d;
  state_t        state_q, state_d;
  logic [SW-1:0] seconds_q, seconds_d;
  logic [PW-1:0] rgb_out_q, rgb_out_d;
  logic [PW-1:0] rgb_dim;
  logic          tick;

  sec_tick #(
    .CLKSPD      (CLKSPD),
    .TICK_CYCLES (TICK_CYCLES)
  ) u_sec_tick (
    .clk_sys (clk_sys),
    .reset   (reset),
    .enable  (state_q != ST_RUN),
    .tick    (tick)
  );

  // Each channel shifted right by one; the vacated MSB fills with zero.
  assign rgb_dim = {rgb_in[RW+GW +: BW] >> 1,
                    rgb_in[RW    +: GW] >> 1,
                    rgb_in[0     +: RW] >> 1};

  always_comb begin
    user_pause_d = user_pause_q ^ (user_button & ~btn_q);
    pause_cpu_d  = user_pause_q | pause_request | (options[0] & OSD_STATUS);

    state_d = state_q;
    case (state_q)
      ST_RUN:    if (pause_cpu_q) state_d = ST_PAUSED;
      ST_PAUSED: if ((seconds_q == SEC_MAX) && options[1]) state_d = ST_DIMMED;
      ST_DIMMED: if (!options[1]) state_d = ST_PAUSED;
      default:   state_d = ST_RUN;
    endcase
    if (!pause_cpu_q) state_d = ST_RUN;

    seconds_d = seconds_q;
    case (state_q)
      ST_RUN:    seconds_d = '0;
      ST_PAUSED: if (tick && (seconds_q != SEC_MAX)) seconds_d = seconds_q + SW'(1);
      default:   seconds_d = seconds_q;
    endcase

    rgb_out_d = (state_q == ST_DIMMED) ? rgb_dim : rgb_in;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      btn_q        <= 1'b0;
      user_pause_q <= 1'b0;
      pause_cpu_q  <= 1'b0;
      state_q      <= ST_RUN;
      seconds_q    <= '0;
      rgb_out_q    <= '0;
    end else begin
      btn_q        <= user_button;
      user_pause_q <= user_pause_d;
      pause_cpu_q  <= pause_cpu_d;
      state_q      <= state_d;
      seconds_q    <= seconds_d;
      rgb_out_q    <= rgb_out_d;
    end
  end

  assign pause_cpu     = pause_cpu_q;
  assign rgb_out       = rgb_out_q;
  assign dbg_state_o   = state_q;
  assign dbg_seconds_o = seconds_q;

endmodule

// File: tb/tb_pause_dim.sv
// Directed bench for pause_dim: a vector table for the pause sources plus
// hand-written sequences for dimming, OSD and asynchronous reset.
module tb_pause_dim;
  import pause_pkg::*;

  localparam int TC = 16;
  localparam int DS = 2;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        user_button;
  logic        pause_request;
  logic        OSD_STATUS;
  logic [1:0]  options;
  logic [11:0] rgb_in;
  logic        pause_cpu;
  logic [11:0] rgb_out;
  state_t      dbg_state;
  logic [1:0]  dbg_seconds;

  int errors = 0;
  int checks = 0;

  pause_dim #(
    .RW (4), .GW (4), .BW (4),
    .CLKSPD (1), .DIM_SECONDS (DS), .TICK_CYCLES (TC)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .user_button   (user_button),
    .pause_request (pause_request),
    .OSD_STATUS    (OSD_STATUS),
    .options       (options),
    .rgb_in        (rgb_in),
    .pause_cpu     (pause_cpu),
    .rgb_out       (rgb_out),
    .dbg_state_o   (dbg_state),
    .dbg_seconds_o (dbg_seconds)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        btn;
    logic        preq;
    logic        osd;
    logic [1:0]  opt;
    logic [11:0] rgb;
    logic        exp_pc;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic press();
    user_button = 1'b1;
    tick();
    user_button = 1'b0;
    tick();
  endtask

  initial begin
    int found;
    int bad;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 12'h123, 1'b0, 12'h123};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'b00, 12'h456, 1'b1, 12'h456};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b00, 12'h789, 1'b1, 12'h789};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'b00, 12'hABC, 1'b1, 12'hABC};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'b00, 12'hDEF, 1'b0, 12'hDEF};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b00, 12'h0F0, 1'b1, 12'h0F0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 12'hF0F, 1'b0, 12'hF0F};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'b01, 12'h321, 1'b1, 12'h321};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'b00, 12'h654, 1'b0, 12'h654};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'b01, 12'h987, 1'b0, 12'h987};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 2'b11, 12'hCBA, 1'b1, 12'hCBA};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 2'b00, 12'h000, 1'b0, 12'h000};

    // Reset state
    reset = 1'b1; user_button = 1'b0; pause_request = 1'b0;
    OSD_STATUS = 1'b0; options = 2'b00; rgb_in = 12'h000;
    #12;
    check("reset_pause_cpu", 32'(pause_cpu), 32'd0);
    check("reset_rgb_out", 32'(rgb_out), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_RUN));
    check("reset_seconds", 32'(dbg_seconds), 32'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    tick();

    // Pause-source vector table, each vector held three cycles
    for (int i = 0; i < 12; i++) begin
      user_button = vecs[i].btn; pause_request = vecs[i].preq;
      OSD_STATUS = vecs[i].osd;  options = vecs[i].opt; rgb_in = vecs[i].rgb;
      tick(3);
      check($sformatf("vec%0d_pause_cpu", i), 32'(pause_cpu), 32'(vecs[i].exp_pc));
      check($sformatf("vec%0d_rgb_out", i), 32'(rgb_out), 32'(vecs[i].exp_rgb));
    end

    // Single press: pause_cpu rises on the second edge, second press clears
    user_button = 1'b1;
    tick();
    check("press_edge1", 32'(pause_cpu), 32'd0);
    user_button = 1'b0;
    tick();
    check("press_edge2", 32'(pause_cpu), 32'd1);
    press();
    check("second_press", 32'(pause_cpu), 32'd0);

    // Button held for 100 cycles toggles only once
    user_button = 1'b1;
    bad = 0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (n >= 2 && pause_cpu !== 1'b1) bad++;
    end
    check("hold_stays_paused", 32'(bad), 32'd0);
    user_button = 1'b0;
    tick(2);
    check("hold_release", 32'(pause_cpu), 32'd1);
    press();
    tick();
    check("hold_clear", 32'(pause_cpu), 32'd0);

    // Button edge in the same cycle pause_request drops
    pause_request = 1'b1;
    tick(2);
    check("preq_paused", 32'(pause_cpu), 32'd1);
    pause_request = 1'b0;
    user_button = 1'b1;
    tick();
    user_button = 1'b0;
    tick();
    check("edge_with_preq_drop", 32'(pause_cpu), 32'd1);
    press();
    tick();
    check("edge_with_preq_clear", 32'(pause_cpu), 32'd0);
    tick(4);
    check("idle_state", 32'(dbg_state), 32'(ST_RUN));

    // Dimming after DS seconds of TC cycles
    options = 2'b10; rgb_in = 12'hFFF; pause_request = 1'b1;
    found = 0; bad = 0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (rgb_out === 12'h777) begin
        found = n;
        break;
      end
      if (rgb_out !== 12'hFFF) bad++;
    end
    check("dim_cycle", 32'(found), 32'(2 * TC + 4));
    check("undimmed_before", 32'(bad), 32'd0);
    check("dim_state", 32'(dbg_state), 32'(ST_DIMMED));
    check("dim_seconds", 32'(dbg_seconds), 32'(DS));

    // Dim enable cleared and restored while dimmed
    options = 2'b00;
    tick();
    check("optclr_state", 32'(dbg_state), 32'(ST_PAUSED));
    check("optclr_seconds", 32'(dbg_seconds), 32'(DS));
    tick();
    check("optclr_rgb", 32'(rgb_out), 32'hFFF);
    options = 2'b10;
    tick();
    check("optset_state", 32'(dbg_state), 32'(ST_DIMMED));
    tick();
    check("optset_rgb", 32'(rgb_out), 32'h777);

    // Drop the pause request while dimmed
    pause_request = 1'b0; rgb_in = 12'h5A3;
    tick(3);
    check("resume_pause_cpu", 32'(pause_cpu), 32'd0);
    check("resume_state", 32'(dbg_state), 32'(ST_RUN));
    check("resume_seconds", 32'(dbg_seconds), 32'd0);
    check("resume_rgb", 32'(rgb_out), 32'h5A3);

    // Asynchronous reset while dimmed
    rgb_in = 12'hFFF; pause_request = 1'b1;
    found = 0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (dbg_state == ST_DIMMED && rgb_out === 12'h777) begin
        found = 1;
        break;
      end
    end
    check("redim_reached", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pause_cpu", 32'(pause_cpu), 32'd0);
    check("async_rst_rgb", 32'(rgb_out), 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'(ST_RUN));
    pause_request = 1'b0; options = 2'b00; rgb_in = 12'hABC;
    @(negedge clk_sys);
    reset = 1'b0;
    tick();
    check("post_rst_rgb", 32'(rgb_out), 32'hABC);
    check("post_rst_pause_cpu", 32'(pause_cpu), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
